// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Define MULT_DIV_UNIT_DIV_EN to build the restoring divider (ops DIV/DIVU).
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t      state, next_state;
    logic [4:0]  count;
    logic        a_neg, b_neg;
    logic [31:0] b_r, acc, shreg;
    logic        launch, last_step;
    logic [31:0] a_mag_in, b_mag;
    logic [31:0] step_acc, step_shreg, res_hi, res_lo;
    logic [32:0] mul_sum;
    logic [63:0] prod, prod_res;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic        div_op;
    logic [31:0] a_r;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
`endif

    assign busy      = (state == RUN);
    assign done      = (state == FIN);
    assign launch    = start && (state != RUN);
    assign last_step = (state == RUN) && (count == 5'd0);
    assign a_mag_in  = (!op[0] && a[31]) ? -a : a;
    assign b_mag     = b_neg ? -b_r : b_r;

    // Without the divider, divide requests complete immediately and leave HI/LO alone.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, FIN: begin
                if (start)
                    next_state = (op[1] && !DIV_EN) ? FIN : RUN;
                else
                    next_state = IDLE;
            end
            RUN:     if (count == 5'd0) next_state = FIN;
            default: next_state = IDLE;
        endcase
    end

    // One iteration step on magnitudes; signs are applied only to the final result.
    always_comb begin
        mul_sum    = {1'b0, acc} + (shreg[0] ? {1'b0, b_mag} : 33'd0);
        step_acc   = mul_sum[32:1];
        step_shreg = {mul_sum[0], shreg[31:1]};
        prod       = {step_acc, step_shreg};
        prod_res   = (a_neg ^ b_neg) ? -prod : prod;
        res_hi     = prod_res[63:32];
        res_lo     = prod_res[31:0];
`ifdef MULT_DIV_UNIT_DIV_EN
        rem_shift  = {acc, shreg[31]};
        rem_ge     = (rem_shift >= {1'b0, b_mag});
        rem_sub    = rem_shift[31:0] - b_mag;
        if (div_op) begin
            step_acc   = rem_ge ? rem_sub : rem_shift[31:0];
            step_shreg = {shreg[30:0], rem_ge};
            if (b_r == 32'd0) begin
                res_hi = a_r;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = a_neg ? -step_acc : step_acc;
                res_lo = (a_neg ^ b_neg) ? -step_shreg : step_shreg;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 5'd0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            b_r   <= 32'd0;
            acc   <= 32'd0;
            shreg <= 32'd0;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_op <= 1'b0;
            a_r    <= 32'd0;
`endif
        end else if (launch) begin
            count <= 5'd31;
            a_neg <= !op[0] && a[31];
            b_neg <= !op[0] && b[31];
            b_r   <= b;
            acc   <= 32'd0;
            shreg <= a_mag_in;
`ifdef MULT_DIV_UNIT_DIV_EN
            div_op <= op[1];
            a_r    <= a;
`endif
        end else if (state == RUN) begin
            count <= count - 5'd1;
            acc   <= step_acc;
            shreg <= step_shreg;
        end
    end

    // Moves are locked out only while iterating, so a move alongside start still lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state != RUN) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 No parameters; datapath width SHALL be fixed at 32 bits.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when not busy.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  32  operand A / dividend, driven from register-file read port 1.
REQ-007 b  input  32  operand B / divisor, driven from register-file read port 2.
REQ-008 hi_we  input  1  move-to-HI strobe.
REQ-009 lo_we  input  1  move-to-LO strobe.
REQ-010 wdata  input  32  data for hi_we/lo_we.
REQ-011 busy  output  1  high while an operation iterates.
REQ-012 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-013 hi  output  32  HI register: product upper word / remainder.
REQ-014 lo  output  32  LO register: product lower word / quotient.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIN; busy SHALL be high only in RUN and done only in FIN.
REQ-016 IDLE or FIN with start=1 at edge N: latch a, b, op; enter RUN; busy=1 from N+1.
REQ-017 RUN SHALL last exactly 32 cycles (5-bit iteration counter, 31 down to 0), one shift-add (multiply) or restoring-subtract (divide) step per cycle.
REQ-018 After the 32nd step (edge N+33): state FIN; hi/lo updated; done=1 for that one cycle; busy=0.
REQ-019 FIN without start SHALL return to IDLE on the next edge; FIN with start SHALL begin a new operation (back-to-back, no idle gap).
REQ-020 start while busy SHALL be ignored; operands and op SHALL NOT be re-latched.
REQ-021 Signed ops SHALL iterate on operand magnitudes and apply sign at completion: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-022 MULT/MULTU: {hi,lo} SHALL equal the exact 64-bit product.
REQ-023 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder.
REQ-024 Divide by zero: full 32-cycle latency; lo=32'hFFFFFFFF, hi=a.
REQ-025 DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-026 hi_we/lo_we SHALL write wdata into hi/lo at the edge only when busy=0; ignored while busy.
REQ-027 Move and start in the same cycle: move applied at that edge; the operation result later overwrites hi and lo.
REQ-028 hi/lo SHALL hold their value at all times other than REQ-018, REQ-026 and reset.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, latched operands=0.
REQ-030 Reset during RUN SHALL abort the operation; no done pulse SHALL follow; first start after reset release SHALL behave per REQ-016.

Configuration
REQ-031 Macro MULT_DIV_UNIT_DIV_EN: when defined, the divider datapath and ops 10/11 SHALL be present as specified.
REQ-032 When MULT_DIV_UNIT_DIV_EN is undefined, no divider logic SHALL be synthesised; start with op 10/11 SHALL go directly to FIN (done at N+1, busy never high) with hi/lo unchanged.

Verification
REQ-033 MULT a=32'hFFFFFFFD (-3), b=5 -> busy N+1..N+32, done at N+33, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-034 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; back-to-back start in FIN cycle -> busy at next cycle, no idle gap.
REQ-035 DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-036 Start MULTU 3*4, assert start with new operands and hi_we (wdata=32'hDEAD) at RUN cycle 5 -> both ignored; done at N+33 with hi=0, lo=12.
REQ-037 Assert reset at RUN cycle 10 -> busy, hi, lo 0 immediately; no done within next 40 cycles.
REQ-038 Build without MULT_DIV_UNIT_DIV_EN, lo_we 32'h55, then DIVU 9/3 -> done at N+1, busy never high, lo stays 32'h55.
